// File: rtl/wave_param_pkg.sv
// rtl/wave_param_pkg.sv - shared widths, defaults, repeat states and key priority order
package wave_param_pkg;

    localparam int CODE_W        = 6;
    localparam int FREQ_MIN_DEF  = 1;
    localparam int FREQ_MAX_DEF  = 20;
    localparam int PHASE_MAX_DEF = 35;

    // Lower index wins when several events land in the same cycle.
    localparam int KEY_FREQ_UP   = 0;
    localparam int KEY_FREQ_DOWN = 1;
    localparam int KEY_PHASE     = 2;
    localparam int KEY_WAVE      = 3;
    localparam int NUM_KEYS      = 4;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/wave_param_ctrl_key_debounce.sv
// rtl/wave_param_ctrl_key_debounce.sv - key synchronizer, stability counter and press pulse
module key_debounce #(
    parameter int DEBOUNCE_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic             level_d;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // Until a stable release has been seen after reset the key is ignored,
    // so a key held through reset cannot generate a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            level_q <= 1'b1;
            level_d <= 1'b1;
            armed   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
            level_d <= level_q;
            if (!armed) begin
                if (!sync_q2) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (sync_q2 == level_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_q <= sync_q2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign key_level = level_q;
    assign press     = level_d & ~level_q;

endmodule

// File: rtl/wave_param_ctrl.sv
// rtl/wave_param_ctrl.sv - key-driven freq/wave/phase parameter registers for the DDS sender
module wave_param_ctrl
    import wave_param_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int HOLD_CNT     = 50_000_000,
    parameter int REPEAT_CNT   = 10_000_000,
    parameter int FREQ_MIN     = FREQ_MIN_DEF,
    parameter int FREQ_MAX     = FREQ_MAX_DEF,
    parameter int PHASE_MAX    = PHASE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_freq_up,
    input  logic              key_freq_down,
    input  logic              key_phase,
    input  logic              key_wave,
    output logic [CODE_W-1:0] freq_select,
    output logic              wave_select,
    output logic [CODE_W-1:0] phase_select,
    output logic              param_valid
);

    localparam int TMR_MAX = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;

    always_comb begin
        key_raw                = '1;
        key_raw[KEY_FREQ_UP]   = key_freq_up;
        key_raw[KEY_FREQ_DOWN] = key_freq_down;
        key_raw[KEY_PHASE]     = key_phase;
        key_raw[KEY_WAVE]      = key_wave;
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_key_debounce (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_raw   (key_raw[i]),
            .key_level (level[i]),
            .press     (press[i])
        );
    end

    logic levels_unused;
    assign levels_unused = level[KEY_PHASE] ^ level[KEY_WAVE];

    rpt_state_t       rpt_state;
    logic             rpt_up;
    logic [TMR_W-1:0] rpt_tmr;
    logic             held_level;
    logic             hold_done;
    logic             repeat_done;
    logic             opposite_press;
    logic             rpt_evt;

    assign held_level     = rpt_up ? level[KEY_FREQ_UP] : level[KEY_FREQ_DOWN];
    assign hold_done      = (rpt_state == RPT_HOLD)   && (rpt_tmr == TMR_W'(HOLD_CNT));
    assign repeat_done    = (rpt_state == RPT_REPEAT) && (rpt_tmr == TMR_W'(REPEAT_CNT));
    assign opposite_press = rpt_up ? press[KEY_FREQ_DOWN] : press[KEY_FREQ_UP];
    assign rpt_evt        = (hold_done || repeat_done) && !held_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_state <= RPT_IDLE;
            rpt_up    <= 1'b0;
            rpt_tmr   <= '0;
        end else begin
            case (rpt_state)
                RPT_IDLE: begin
                    rpt_tmr <= '0;
                    if (press[KEY_FREQ_UP]) begin
                        rpt_state <= RPT_HOLD;
                        rpt_up    <= 1'b1;
                    end else if (press[KEY_FREQ_DOWN]) begin
                        rpt_state <= RPT_HOLD;
                        rpt_up    <= 1'b0;
                    end
                end
                default: begin
                    if (opposite_press) begin
                        rpt_state <= RPT_HOLD;
                        rpt_up    <= ~rpt_up;
                        rpt_tmr   <= '0;
                    end else if (held_level) begin
                        rpt_state <= RPT_IDLE;
                        rpt_tmr   <= '0;
                    end else if (hold_done || repeat_done) begin
                        rpt_state <= RPT_REPEAT;
                        rpt_tmr   <= '0;
                    end else begin
                        rpt_tmr <= rpt_tmr + 1'b1;
                    end
                end
            endcase
        end
    end

    logic              evt_up;
    logic              evt_down;
    logic [CODE_W-1:0] freq_n;
    logic              wave_n;
    logic [CODE_W-1:0] phase_n;

    assign evt_up   = press[KEY_FREQ_UP]   | (rpt_evt &  rpt_up);
    assign evt_down = press[KEY_FREQ_DOWN] | (rpt_evt & ~rpt_up);

    // One event per cycle; anything of lower priority is dropped.
    always_comb begin
        freq_n  = freq_select;
        wave_n  = wave_select;
        phase_n = phase_select;
        if (evt_up) begin
            if (freq_select != CODE_W'(FREQ_MAX)) freq_n = freq_select + 1'b1;
        end else if (evt_down) begin
            if (freq_select != CODE_W'(FREQ_MIN)) freq_n = freq_select - 1'b1;
        end else if (press[KEY_PHASE]) begin
            phase_n = (phase_select == CODE_W'(PHASE_MAX)) ? '0 : phase_select + 1'b1;
        end else if (press[KEY_WAVE]) begin
            wave_n = ~wave_select;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_select  <= CODE_W'(FREQ_MIN);
            wave_select  <= 1'b0;
            phase_select <= '0;
            param_valid  <= 1'b0;
        end else begin
            freq_select  <= freq_n;
            wave_select  <= wave_n;
            phase_select <= phase_n;
            param_valid  <= (freq_n != freq_select) || (wave_n != wave_select) ||
                            (phase_n != phase_select);
        end
    end

endmodule

// File: tb/tb_wave_param_ctrl.sv
// tb/tb_wave_param_ctrl.sv - scoreboard bench for wave_param_ctrl against a behavioural model
module tb_wave_param_ctrl;

    localparam int DEB   = 4;
    localparam int HOLD  = 16;
    localparam int REP   = 8;
    localparam int FMIN  = 1;
    localparam int FMAX  = 20;
    localparam int PMAX  = 35;
    localparam int LAT   = DEB + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] keys = 4'hF;
    logic [5:0] freq_select;
    logic       wave_select;
    logic [5:0] phase_select;
    logic       param_valid;

    wave_param_ctrl #(
        .DEBOUNCE_CNT (DEB),
        .HOLD_CNT     (HOLD),
        .REPEAT_CNT   (REP),
        .FREQ_MIN     (FMIN),
        .FREQ_MAX     (FMAX),
        .PHASE_MAX    (PMAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_freq_up   (keys[0]),
        .key_freq_down (keys[1]),
        .key_phase     (keys[2]),
        .key_wave      (keys[3]),
        .freq_select   (freq_select),
        .wave_select   (wave_select),
        .phase_select  (phase_select),
        .param_valid   (param_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int f;
        int w;
        int p;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;
    int   mfreq = FMIN;
    int   mwave = 0;
    int   mphase = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_apply(input int k);
        case (k)
            0: if (mfreq < FMAX) begin mfreq++; return 1'b1; end
            1: if (mfreq > FMIN) begin mfreq--; return 1'b1; end
            2: begin mphase = (mphase == PMAX) ? 0 : mphase + 1; return 1'b1; end
            3: begin mwave = 1 - mwave; return 1'b1; end
            default: return 1'b0;
        endcase
        return 1'b0;
    endfunction

    function automatic void push_exp(input int t);
        exp_t e;
        e.t = t; e.f = mfreq; e.w = mwave; e.p = mphase;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (param_valid) begin
            exp_t e;
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("strobe_cycle", cyc, e.t);
                check("strobe_freq", int'(freq_select), e.f);
                check("strobe_wave", int'(wave_select), e.w);
                check("strobe_phase", int'(phase_select), e.p);
            end
        end
    end

    task automatic check_model(input string name);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_freq"}, int'(freq_select), mfreq);
        check({name, "_wave"}, int'(wave_select), mwave);
        check({name, "_phase"}, int'(phase_select), mphase);
    endtask

    task automatic tap(input int k, input int low, input int high);
        @(negedge clk);
        keys[k] = 1'b0;
        if (model_apply(k)) push_exp(cyc + LAT);
        repeat (low) @(negedge clk);
        keys[k] = 1'b1;
        repeat (high) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_freq", int'(freq_select), FMIN);
        check("rst_wave", int'(wave_select), 0);
        check("rst_phase", int'(phase_select), 0);
        check("rst_valid", int'(param_valid), 0);
        check("rst_pending", exp_q.size(), 0);
        exp_q.delete();
        mfreq = FMIN; mwave = 0; mphase = 0;
    endtask

    // Hold a key for 'hold' cycles past its press update, then release it or reset.
    task automatic hold_key(input int k, input int hold, input bit do_reset);
        int first;
        int lim;
        int t;
        @(negedge clk);
        keys[k] = 1'b0;
        first = cyc + LAT;
        if (model_apply(k)) push_exp(first);
        lim = first + hold + (do_reset ? 0 : DEB + 3);
        t = first + HOLD + 1;
        while (t <= lim) begin
            if (model_apply(k)) push_exp(t);
            t += REP + 1;
        end
        while (cyc < first + hold) @(negedge clk);
        if (do_reset) apply_reset();
        else keys[k] = 1'b1;
    endtask

    int s0;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_freq", int'(freq_select), FMIN);
        check("reset_wave", int'(wave_select), 0);
        check("reset_phase", int'(phase_select), 0);
        check("reset_valid", int'(param_valid), 0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_no_strobe", strobes, 0);

        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            keys[2] = 1'b0;
            repeat (2) @(negedge clk);
            keys[2] = 1'b1;
            repeat (2) @(negedge clk);
        end
        keys[2] = 1'b0;
        if (model_apply(2)) push_exp(cyc + LAT);
        repeat (12) @(negedge clk);
        keys[2] = 1'b1;
        repeat (15) @(negedge clk);
        check("bounce_strobes", strobes, 1);
        check_model("bounce");

        s0 = strobes;
        tap(1, 10, 12);
        check("down_sat_no_strobe", strobes - s0, 0);
        for (int i = 0; i < 19; i++) tap(0, 10, 12);
        check("freq_up_to_max", int'(freq_select), FMAX);
        s0 = strobes;
        tap(0, 10, 12);
        check("up_sat_no_strobe", strobes - s0, 0);
        check_model("limits");

        @(negedge clk);
        apply_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        s0 = strobes;
        hold_key(0, 50, 1'b0);
        repeat (30) @(negedge clk);
        check("repeat_strobes", strobes - s0, 6);
        check("repeat_freq", int'(freq_select), 7);
        check_model("repeat");

        @(negedge clk);
        keys[0] = 1'b0; keys[2] = 1'b0; keys[3] = 1'b0;
        if (model_apply(0)) push_exp(cyc + LAT);
        repeat (12) @(negedge clk);
        keys = 4'hF;
        repeat (15) @(negedge clk);
        check_model("simul");

        s0 = strobes;
        for (int i = 0; i < 36; i++) tap(2, 10, 12);
        check("phase_wrap", int'(phase_select), 0);
        check("phase_wrap_strobes", strobes - s0, 36);
        tap(3, 10, 12);
        check("wave_first", int'(wave_select), 1);
        tap(3, 10, 12);
        check("wave_second", int'(wave_select), 0);
        check_model("wave");

        for (int i = 0; i < 24; i++)
            tap(int'($urandom_range(0, 3)), int'($urandom_range(9, 14)),
                int'($urandom_range(10, 18)));
        repeat (10) @(negedge clk);
        check_model("random");

        hold_key(0, 40, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s0 = strobes;
        repeat (100) @(negedge clk);
        check("held_after_reset_no_strobe", strobes - s0, 0);
        keys[0] = 1'b1;
        repeat (30) @(negedge clk);
        tap(0, 10, 15);
        check("rearm_freq", int'(freq_select), FMIN + 1);
        check_model("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
